// File: rtl/main_memory_ctrl.sv
// Round-robin request sequencer in front of MainMemory: one line transaction
// at a time, absorbing the memory's one-cycle registered read latency.
module main_memory_ctrl #(
  parameter int N_REQ  = 2,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 9,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ-1:0]           req_we,
  input  logic [N_REQ*ADDR_W-1:0]    req_addr,
  input  logic [N_REQ*DATA_W-1:0]    req_wdata,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       rsp_valid,
  output logic [ID_W-1:0]            rsp_id,
  output logic                       rsp_we,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  output logic                       mem_we,
  input  logic [DATA_W-1:0]          mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     rr_q, rr_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic [ADDR_W-1:0]   req_addr_arr  [N_REQ];
  logic [DATA_W-1:0]   req_wdata_arr [N_REQ];
  logic                grant_found;
  logic [ID_W-1:0]     grant_id;
  logic [ID_W-1:0]     cand;

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign req_addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
    assign req_wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
  end

  // Search upward from the requester just after the last winner, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = ID_W'((int'(rr_q) + i) % N_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    id_d      = id_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    req_ready = '0;
    case (state_q)
      IDLE: begin
        if (!reset && grant_found) begin
          req_ready[grant_id] = 1'b1;
          rr_d    = grant_id;
          id_d    = grant_id;
          we_d    = req_we[grant_id];
          addr_d  = req_addr_arr[grant_id];
          wdata_d = req_wdata_arr[grant_id];
          rdata_d = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = we_q ? RESP : WAIT;
      WAIT: begin
        rdata_d = mem_rdata;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode from state only, so an async reset clears them at once.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    rsp_valid = 1'b0;
    rsp_id    = '0;
    rsp_we    = 1'b0;
    rsp_rdata = '0;
    if (state_q != IDLE) begin
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
    end
    if (state_q == ISSUE) begin
      mem_we = we_q;
    end
    if (state_q == RESP) begin
      rsp_valid = 1'b1;
      rsp_id    = id_q;
      rsp_we    = we_q;
      rsp_rdata = rdata_q;
    end
  end

  // Pointer starts at the top so requester 0 wins the first arbitration.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rr_q    <= ID_W'(N_REQ - 1);
      id_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_main_memory_ctrl.sv
// Scoreboard bench for main_memory_ctrl with a MainMemory model and a
// transaction-level reference of arbitration, timing and memory contents.
module tb_main_memory_ctrl;

  localparam int N  = 2;
  localparam int DW = 64;
  localparam int AW = 9;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid, req_we, req_ready;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic            rsp_valid, rsp_we, mem_we;
  logic [0:0]      rsp_id;
  logic [DW-1:0]   rsp_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0]   mem_addr;

  main_memory_ctrl #(.N_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_we(rsp_we),
    .rsp_rdata(rsp_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // MainMemory: synchronous write, registered read.
  logic [DW-1:0] mem [512];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  function automatic logic [DW-1:0] preload(int a);
    return 64'h1000_0000_0000_0000 + 64'(a) * 64'h0001_0003_0007_000B;
  endfunction

  typedef struct { int cyc; logic [AW-1:0] addr; bit we; logic [DW-1:0] data; } iss_t;
  typedef struct { int cyc; int id; bit we; logic [DW-1:0] data; } rsp_t;

  iss_t iss_q[$];
  rsp_t rsp_q[$];
  int   grants[$];
  int   grant_cyc[$];

  logic [DW-1:0] ref_mem [512];
  int   last_grant;
  int   next_free;
  bit   refill;
  int   total = 0;
  int   bad   = 0;

  bit            pend_v  [N];
  bit            pend_we [N];
  logic [AW-1:0] pend_a  [N];
  logic [DW-1:0] pend_d  [N];

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic int pick(bit v [N], int last);
    for (int i = last + 1; i < N; i++) if (v[i]) return i;
    for (int i = 0; i <= last; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] pool [6];
    pool = '{9'h000, 9'h005, 9'h0FF, 9'h100, 9'h1A0, 9'h1FF};
    return pool[$urandom_range(0, 5)];
  endfunction

  task automatic submit(int r, bit we, logic [AW-1:0] a, logic [DW-1:0] d);
    pend_v[r] = 1'b1; pend_we[r] = we; pend_a[r] = a; pend_d[r] = d;
  endtask

  // One cycle: drive requests, compare req_ready with the reference, record
  // the expected memory access and response for any handshake.
  task automatic step();
    int g;
    logic [N-1:0] exp_rdy;
    iss_t it;
    rsp_t rt;
    for (int r = 0; r < N; r++) begin
      req_valid[r]            = pend_v[r];
      req_we[r]               = pend_we[r];
      req_addr[r*AW +: AW]    = pend_a[r];
      req_wdata[r*DW +: DW]   = pend_d[r];
    end
    #1;
    g = -1;
    if (!reset && cyc >= next_free) g = pick(pend_v, last_grant);
    exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    if (g >= 0) begin
      it.cyc = cyc + 1; it.addr = pend_a[g]; it.we = pend_we[g]; it.data = pend_d[g];
      iss_q.push_back(it);
      rt.id = g; rt.we = pend_we[g];
      if (pend_we[g]) begin
        ref_mem[pend_a[g]] = pend_d[g];
        rt.data = '0; rt.cyc = cyc + 2; next_free = cyc + 3;
      end else begin
        rt.data = ref_mem[pend_a[g]]; rt.cyc = cyc + 3; next_free = cyc + 4;
      end
      rsp_q.push_back(rt);
      last_grant = g;
      grants.push_back(g);
      grant_cyc.push_back(cyc);
      pend_v[g] = 1'b0;
      if (refill) submit(g, 1'b0, rand_addr(), '0);
    end
    @(negedge clk);
  endtask

  task automatic drain();
    for (int k = 0; k < 200; k++) begin
      if (!pend_v[0] && !pend_v[1] && rsp_q.size() == 0 && iss_q.size() == 0) return;
      step();
    end
    check("drain_timeout", 64'(rsp_q.size() + iss_q.size()), 64'd0);
  endtask

  task automatic check_outputs_zero(string tag);
    check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, "_rsp_id"},    64'(rsp_id),    64'd0);
    check({tag, "_rsp_we"},    64'(rsp_we),    64'd0);
    check({tag, "_rsp_rdata"}, rsp_rdata,      64'd0);
    check({tag, "_mem_addr"},  64'(mem_addr),  64'd0);
    check({tag, "_mem_wdata"}, mem_wdata,      64'd0);
    check({tag, "_mem_we"},    64'(mem_we),    64'd0);
  endtask

  // Monitor: compares memory-side accesses and responses against the queues.
  always @(negedge clk) begin
    if (!reset) begin
      if (iss_q.size() > 0 && iss_q[0].cyc == cyc) begin
        iss_t it;
        it = iss_q.pop_front();
        check("mem_addr", 64'(mem_addr), 64'(it.addr));
        check("mem_we", 64'(mem_we), 64'(it.we));
        if (it.we) check("mem_wdata", mem_wdata, it.data);
      end else if (mem_we) begin
        check("spurious_mem_we", 64'(mem_we), 64'd0);
      end
      if (rsp_valid) begin
        if (rsp_q.size() == 0) begin
          check("unexpected_rsp", 64'(rsp_valid), 64'd0);
        end else begin
          rsp_t rt;
          rt = rsp_q.pop_front();
          check("rsp_cycle", 64'(cyc), 64'(rt.cyc));
          check("rsp_id", 64'(rsp_id), 64'(rt.id));
          check("rsp_we", 64'(rsp_we), 64'(rt.we));
          check("rsp_rdata", rsp_rdata, rt.data);
        end
      end else if (rsp_q.size() > 0 && rsp_q[0].cyc < cyc) begin
        rsp_t rt;
        rt = rsp_q.pop_front();
        check("rsp_missing", 64'(cyc), 64'(rt.cyc));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int base;
    for (int a = 0; a < 512; a++) begin
      mem[a]     = preload(a);
      ref_mem[a] = preload(a);
    end
    mem_rdata = '0;
    reset = 1'b1;
    refill = 1'b0;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    for (int r = 0; r < N; r++) begin
      pend_v[r] = 1'b0; pend_we[r] = 1'b0; pend_a[r] = '0; pend_d[r] = '0;
    end
    last_grant = N - 1;
    next_free  = 0;

    // Outputs held at zero under reset even with a request present.
    @(negedge clk);
    submit(0, 1'b0, 9'h005, '0);
    step();
    check_outputs_zero("in_reset");
    pend_v[0] = 1'b0;
    step();
    reset = 1'b0;
    last_grant = N - 1;
    next_free  = 0;

    $display("[TB] first read from requester 0");
    submit(0, 1'b0, 9'h005, '0);
    drain();

    $display("[TB] write then read-back of 0x1A0");
    submit(1, 1'b1, 9'h1A0, 64'hDEADBEEF_01234567);
    drain();
    submit(0, 1'b0, 9'h1A0, '0);
    drain();

    $display("[TB] continuous contention");
    submit(1, 1'b0, 9'h010, '0);
    drain();
    base = grants.size();
    refill = 1'b1;
    submit(0, 1'b0, 9'h020, '0);
    submit(1, 1'b0, 9'h021, '0);
    for (int k = 0; k < 16; k++) step();
    refill = 1'b0;
    drain();
    for (int i = 0; i < 4; i++) begin
      check("alt_grant", 64'(grants[base + i]), 64'(i % 2));
      check("grant_spacing", 64'(grant_cyc[base + i + 1] - grant_cyc[base + i]), 64'd4);
    end

    $display("[TB] write then immediate read, different requesters");
    submit(1, 1'b1, 9'h033, 64'h0123_4567_89AB_CDEF);
    step();
    submit(0, 1'b0, 9'h033, '0);
    drain();

    $display("[TB] page boundary");
    submit(0, 1'b1, 9'h0FF, 64'hAAAA_0000_0000_00FF);
    drain();
    submit(1, 1'b1, 9'h100, 64'h5555_0000_0000_0100);
    drain();
    submit(0, 1'b0, 9'h0FF, '0);
    drain();
    submit(1, 1'b0, 9'h100, '0);
    drain();

    $display("[TB] random traffic");
    for (int k = 0; k < 120; k++) begin
      for (int r = 0; r < N; r++) begin
        if (!pend_v[r] && $urandom_range(0, 2) == 0)
          submit(r, 1'($urandom_range(0, 1)), rand_addr(), {$urandom, $urandom});
      end
      step();
    end
    drain();

    $display("[TB] reset during read wait");
    submit(0, 1'b0, 9'h0A3, '0);
    base = grants.size();
    step();
    check("abort_granted", 64'(grants.size() - base), 64'd1);
    step();
    submit(0, 1'b0, 9'h0A4, '0);
    submit(1, 1'b0, 9'h0A5, '0);
    reset = 1'b1;
    #1;
    check_outputs_zero("abort");
    rsp_q.delete();
    iss_q.delete();
    step();
    step();
    step();
    reset = 1'b0;
    last_grant = N - 1;
    next_free  = 0;
    base = grants.size();
    step();
    check("post_reset_winner", 64'(grants[base]), 64'd0);
    drain();
    for (int k = 0; k < 4; k++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
